// File: rtl/loop_sequencer_if.sv
// Stream/command bundle between the loop sequencer and its controller and datapath.
// The master modport is the sequencer side: it takes commands and produces index beats.
interface loop_sequencer_if #(
    parameter int unsigned BW_O = 8,
    parameter int unsigned BW_I = 8
);
    logic            start;
    logic            abort;
    logic [BW_O-1:0] len_o;
    logic [BW_I-1:0] len_i;
    logic            ready;
    logic            valid;
    logic [BW_O-1:0] idx_o;
    logic [BW_I-1:0] idx_i;
    logic            first_i;
    logic            last_i;
    logic            last;
    logic            busy;
    logic            done;

    modport master (
        input  start, abort, len_o, len_i, ready,
        output valid, idx_o, idx_i, first_i, last_i, last, busy, done
    );

    modport slave (
        output start, abort, len_o, len_i, ready,
        input  valid, idx_o, idx_i, first_i, last_i, last, busy, done
    );
endinterface

// File: rtl/loop_sequencer.sv
// Two-level (outer x inner) index generator with a valid/ready beat stream
// and a one-cycle done pulse after the final beat is accepted.
module loop_sequencer #(
    parameter int unsigned BW_O = 8,
    parameter int unsigned BW_I = 8
) (
    input logic              i_clk,
    input logic              i_rst_n,
    loop_sequencer_if.master bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t          r_state;
    logic [BW_O-1:0] r_len_o;
    logic [BW_I-1:0] r_len_i;
    logic [BW_O-1:0] r_idx_o;
    logic [BW_I-1:0] r_idx_i;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;

    logic w_accept;
    logic w_last_i;
    logic w_last_o;

    // Lengths are nonzero whenever these matter, so len-1 cannot underflow.
    assign w_accept = r_valid && bus.ready;
    assign w_last_i = (r_idx_i == r_len_i - BW_I'(1));
    assign w_last_o = (r_idx_o == r_len_o - BW_O'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_len_o <= '0;
            r_len_i <= '0;
            r_idx_o <= '0;
            r_idx_i <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_state <= StIdle;
                r_idx_o <= '0;
                r_idx_i <= '0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (bus.start) begin
                            r_len_o <= bus.len_o;
                            r_len_i <= bus.len_i;
                            r_idx_o <= '0;
                            r_idx_i <= '0;
                            r_busy  <= 1'b1;
                            if (bus.len_o == '0 || bus.len_i == '0) begin
                                r_state <= StFin;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= StRun;
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (w_accept) begin
                            if (w_last_i && w_last_o) begin
                                // Final beat: indices keep their last values.
                                r_state <= StFin;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (w_last_i) begin
                                r_idx_i <= '0;
                                r_idx_o <= r_idx_o + BW_O'(1);
                            end else begin
                                r_idx_i <= r_idx_i + BW_I'(1);
                            end
                        end
                    end
                    StFin: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.valid   = r_valid;
    assign bus.idx_o   = r_idx_o;
    assign bus.idx_i   = r_idx_i;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.first_i = r_valid && (r_idx_i == '0);
    assign bus.last_i  = r_valid && w_last_i;
    assign bus.last    = r_valid && w_last_i && w_last_o;
endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer: expected beats are queued at start
// and popped as the DUT delivers accepted beats.
module tb_loop_sequencer;
    typedef struct packed {
        logic [7:0] o;
        logic [7:0] i;
        logic       f;
        logic       li;
        logic       l;
    } beat_t;

    logic  clk;
    logic  rst_n;
    int    n_checks;
    int    n_pass;
    beat_t exp_q[$];

    loop_sequencer_if #(.BW_O(8), .BW_I(8)) bus ();

    loop_sequencer #(.BW_O(8), .BW_I(8)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) check_eq("done_vs_valid", 32'(bus.valid), 32'd0);
            if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 32'(bus.valid), 32'd0);
                end else begin
                    beat_t got;
                    got = '{bus.idx_o, bus.idx_i, bus.first_i, bus.last_i, bus.last};
                    if (bus.ready) begin
                        check_eq("beat", 32'(got), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end else begin
                        check_eq("hold", 32'(got), 32'(exp_q[0]));
                    end
                end
            end else begin
                check_eq("flags_idle", 32'({bus.first_i, bus.last_i, bus.last}), 32'd0);
            end
        end
    end

    task automatic push_beats(input int lo, input int li);
        beat_t b;
        for (int o = 0; o < lo; o++) begin
            for (int i = 0; i < li; i++) begin
                b.o  = 8'(o);
                b.i  = 8'(i);
                b.f  = (i == 0);
                b.li = (i == li - 1);
                b.l  = (o == lo - 1) && (i == li - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // mode 0: ready high; mode 1: ready pattern; mode 2: ready high plus start pulses mid-run
    task automatic run_seq(input int lo, input int li, input int mode);
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int n;
        int acc;
        int exp_done;
        int c;
        int r;
        n = lo * li;
        acc = 0;
        exp_done = 1;
        for (int k = 1; acc < n; k++) begin
            r = (mode == 1 && k <= 7) ? pat[k-1] : 1;
            acc += r;
            if (acc == n) exp_done = k + 1;
        end
        push_beats(lo, li);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len_o = 8'(lo);
        bus.len_i = 8'(li);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c = 1;
        while (c <= exp_done + 20) begin
            bus.ready = (mode == 1 && c <= 7) ? pat[c-1][0] : 1'b1;
            if (mode == 2 && (c == 3 || c == 7)) begin
                bus.start = 1'b1;
                bus.len_o = 8'd1;
                bus.len_i = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) break;
            @(posedge clk);
            #1;
            c++;
        end
        bus.start = 1'b0;
        check_eq("done_cycle", 32'(c), 32'(exp_done));
        check_eq("busy_at_done", 32'(bus.busy), 32'd1);
        check_eq("valid_at_done", 32'(bus.valid), 32'd0);
        check_eq("beats_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("done_width", 32'(bus.done), 32'd0);
        check_eq("busy_after", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 32'({bus.valid, bus.busy, bus.done, bus.idx_o, bus.idx_i,
                           bus.first_i, bus.last_i, bus.last}), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len_o = '0;
        bus.len_i = '0;
        bus.ready = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset_hold");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_all_zero("idle_after_reset");
        end

        run_seq(3, 4, 0);
        run_seq(2, 2, 1);
        run_seq(0, 5, 0);
        run_seq(1, 255, 0);

        // Abort after the 6th beat is accepted
        push_beats(4, 4);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len_o = 8'd4;
        bus.len_i = 8'd4;
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_all_zero("after_abort");
        end
        run_seq(4, 4, 0);

        run_seq(3, 4, 2);

        // Asynchronous reset mid-run clears outputs before any clock edge
        push_beats(4, 4);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len_o = 8'd4;
        bus.len_i = 8'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_eq("busy_before_reset", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_seq(3, 4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Two-level loop index generator that drives the MemN2N datapath through an outer × inner iteration space, e.g. memory slot × embedding element. It is the initiator side of the counter `en`/`done` pairing. It accepts a single start command, emits one index pair per beat on a valid/ready stream, and signals a one-cycle completion pulse. It replaces the ad-hoc chaining of single counters in the controller with one back-pressure-aware block.

## Interface
- `BW_O`, 8, width of the outer index and the outer length
- `BW_I`, 8, width of the inner index and the inner length
- `clk`  in  1  system clock, all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe, sampled only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE with no `done`
- `len_o`  in  BW_O  outer iteration count (0 = empty run), captured on accepted `start`
- `len_i`  in  BW_I  inner iteration count (0 = empty run), captured on accepted `start`
- `ready`  in  1  downstream accepts the current beat
- `valid`  out  1  `idx_o`/`idx_i` hold a beat
- `idx_o`  out  BW_O  outer index, 0..len_o-1
- `idx_i`  out  BW_I  inner index, 0..len_i-1
- `first_i`  out  1  beat has `idx_i` == 0
- `last_i`  out  1  beat has `idx_i` == len_i-1
- `last`  out  1  final beat of the run
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse after the final beat is accepted

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - `start`=1 captures `len_o`/`len_i` and clears both indices.
  - If either length is 0, go to FIN. Otherwise go to RUN.
- RUN:
  - `valid`=1. A beat is accepted when `valid`&&`ready`.
  - On an accepted beat, `idx_i` increments.
  - When `idx_i`==len_i-1, `idx_i` wraps to 0 and `idx_o` increments.
  - When the accepted beat also has `idx_o`==len_o-1, go to FIN. Indices hold their final values.
- FIN: `done`=1 and `valid`=0 for exactly one cycle, then go to IDLE.
- Without `ready`, indices and flags hold stable while `valid` stays high. The beat never changes or drops under back-pressure.
- `start` is ignored in RUN and FIN. There is no queuing, and the captured lengths stay in use.
- `abort` has priority over `start` and over beat acceptance:
  - From any state, go to IDLE next cycle with `valid`=0, no `done`, indices cleared.
  - `abort` and `start` in the same IDLE cycle: stay in IDLE.
- Flag generation:
  - `first_i`, `last_i` and `last` are combinational from the registered indices and captured lengths.
  - They are qualified by `valid`, so all three are 0 when `valid`=0.
- Arithmetic and widths:
  - Compares against len-1 use the captured length at full width.
  - len = 2^BW-1 is legal. The index never exceeds len-1, so there is no overflow.
- Reset (async, `rst_n`=0): state IDLE. All outputs read 0, and both captured lengths read 0. Reset during RUN abandons the run without `done`.

## Timing
- `start` accepted at edge k:
  - `busy` and `valid` are high from cycle k+1.
  - The first beat (0,0) is presented in cycle k+1.
- With `ready` held high, one beat per cycle and N = len_o·len_i beats.
  - The last beat is in cycle k+N.
  - `done` is high in cycle k+N+1.
  - `busy` falls in cycle k+N+2.
- Each cycle with `ready` low adds one cycle to the schedule.
- Empty run: `busy` in k+1 with `done` high in the same cycle, and no `valid` at any point.
- Back-to-back runs: a `start` in the first IDLE cycle after FIN is accepted, giving a minimum 2-cycle gap between the last beat and the next first beat.
- `done` never coincides with `valid`. `busy` is 1 during the `done` cycle.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, release, and wait 5 cycles with `start`=0.
  - Required: `valid`, `busy`, `done`, `idx_o`, `idx_i` all remain 0.
- Full-rate run with `len_o`=3, `len_i`=4, `ready`=1:
  - 12 beats in order (0,0),(0,1),…,(2,3).
  - `first_i` on beats 1/5/9, `last_i` on beats 4/8/12, `last` only on beat 12.
  - `done` exactly 1 cycle, 13 cycles after `start`.
- Back-pressure with `len_o`=2, `len_i`=2 and `ready` toggling 1,0,0,1,0,1,1:
  - Indices hold during every `ready`=0 cycle.
  - Exactly 4 beats are accepted and `done` follows the 4th acceptance by 1 cycle.
- Empty and maximum lengths:
  - `len_o`=0, `len_i`=5 gives no `valid` and `done` 1 cycle after `start`.
  - `len_o`=1, `len_i`=255 gives 255 beats with `idx_i` ending at 254 and no wrap of `idx_o`.
- Abort mid-run with `len_o`=4, `len_i`=4, `abort` pulsed after beat 6:
  - `valid` drops next cycle, no `done` pulse, indices read 0.
  - A new `start` then runs to completion from (0,0).
- Start while busy and async reset:
  - `start` pulses during RUN leave the beat sequence and the captured lengths unchanged.
  - Asserting `rst_n`=0 mid-run clears all outputs immediately, without waiting for a clock edge.
